// File: rtl/clk_rst_sequencer.sv
// rtl/clk_rst_sequencer.sv - MMCM reset, lock qualification and staged downstream reset release
// Outputs are registered from the next state, so they move on the same edge as the state register.
module clk_rst_sequencer #(
    parameter int MMCM_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 1024,
    parameter int STABLE_CYCLES   = 64,
    parameter int STAGE_CYCLES    = 16,
    parameter int TICK_DIV        = 9
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       locked_uart_i,
    input  logic       locked_adc_i,
    input  logic       restart_i,
    output logic       mmcm_rst_o,
    output logic       adc_rst_no,
    output logic       fir_rst_no,
    output logic       ctrl_rst_no,
    output logic       ready_o,
    output logic       uart_tick_o,
    output logic [7:0] retry_cnt_o,
    output logic       lock_loss_o
);

    localparam int MAX_A   = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > STAGE_CYCLES) ? STABLE_CYCLES : STAGE_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TICK_W  = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0]  MRST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STAGE_LAST   = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_MRST, S_WAIT, S_STABLE, S_ADC, S_FIR, S_RUN, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [7:0]          retry_q, retry_d;
    logic                lock_loss_q, lock_loss_d;
    logic                mmcm_rst_q, mmcm_rst_d;
    logic                adc_rst_n_q, adc_rst_n_d;
    logic                fir_rst_n_q, fir_rst_n_d;
    logic                ctrl_rst_n_q, ctrl_rst_n_d;
    logic                ready_q, ready_d;
    logic                tick_q, tick_d;
    logic [1:0]          lock_meta_q, lock_sync_q;
    logic                lock_ok;
    logic                in_release;

    // Two-flop synchronisers for the asynchronous MMCM lock flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta_q <= 2'b00;
            lock_sync_q <= 2'b00;
        end else begin
            lock_meta_q <= {locked_uart_i, locked_adc_i};
            lock_sync_q <= lock_meta_q;
        end
    end

    assign lock_ok    = &lock_sync_q;
    assign in_release = (state_q == S_ADC) || (state_q == S_FIR) || (state_q == S_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_d     = retry_q;
        lock_loss_d = lock_loss_q | (in_release && !lock_ok);

        case (state_q)
            S_MRST:   if (cnt_q == MRST_LAST) state_d = S_WAIT;
            S_WAIT: begin
                if (lock_ok) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_MRST;
                    if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
                end
            end
            S_STABLE: begin
                if (!lock_ok)                    state_d = S_WAIT;
                else if (cnt_q == STABLE_LAST)   state_d = S_ADC;
            end
            S_ADC: begin
                if (!lock_ok)                    state_d = S_FAULT;
                else if (cnt_q == STAGE_LAST)    state_d = S_FIR;
            end
            S_FIR: begin
                if (!lock_ok)                    state_d = S_FAULT;
                else if (cnt_q == STAGE_LAST)    state_d = S_RUN;
            end
            S_RUN:    if (!lock_ok) state_d = S_FAULT;
            S_FAULT:  state_d = S_MRST;
            default:  state_d = S_MRST;
        endcase

        // Software restart overrides everything except an MRST already in progress
        if (restart_i && (state_q != S_MRST)) begin
            state_d = S_MRST;
            retry_d = retry_q;
        end

        if ((state_d != state_q) || (state_q == S_RUN)) cnt_d = '0;

        tick_cnt_d = '0;
        tick_d     = 1'b0;
        if ((state_q == S_RUN) && (state_d == S_RUN)) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end

        mmcm_rst_d   = (state_d == S_MRST);
        adc_rst_n_d  = (state_d == S_ADC) || (state_d == S_FIR) || (state_d == S_RUN);
        fir_rst_n_d  = (state_d == S_FIR) || (state_d == S_RUN);
        ctrl_rst_n_d = (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_MRST;
            cnt_q        <= '0;
            tick_cnt_q   <= '0;
            retry_q      <= 8'd0;
            lock_loss_q  <= 1'b0;
            mmcm_rst_q   <= 1'b1;
            adc_rst_n_q  <= 1'b0;
            fir_rst_n_q  <= 1'b0;
            ctrl_rst_n_q <= 1'b0;
            ready_q      <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            retry_q      <= retry_d;
            lock_loss_q  <= lock_loss_d;
            mmcm_rst_q   <= mmcm_rst_d;
            adc_rst_n_q  <= adc_rst_n_d;
            fir_rst_n_q  <= fir_rst_n_d;
            ctrl_rst_n_q <= ctrl_rst_n_d;
            ready_q      <= ready_d;
            tick_q       <= tick_d;
        end
    end

    assign mmcm_rst_o  = mmcm_rst_q;
    assign adc_rst_no  = adc_rst_n_q;
    assign fir_rst_no  = fir_rst_n_q;
    assign ctrl_rst_no = ctrl_rst_n_q;
    assign ready_o     = ready_q;
    assign uart_tick_o = tick_q;
    assign retry_cnt_o = retry_q;
    assign lock_loss_o = lock_loss_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// tb/tb_clk_rst_sequencer.sv - directed bench for clk_rst_sequencer with an edge-indexed scoreboard
module tb_clk_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       locked_uart_i, locked_adc_i, restart_i;
    logic       mmcm_rst_o, adc_rst_no, fir_rst_no, ctrl_rst_no, ready_o, uart_tick_o, lock_loss_o;
    logic [7:0] retry_cnt_o;
    logic       s_mmcm, s_adc, s_fir, s_ctrl, s_rdy, s_tick, s_ll;
    logic [7:0] s_retry;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        string       tag;
        int          edge_at;
        logic [14:0] val;
    } exp_t;
    exp_t sb[$];

    clk_rst_sequencer dut (
        .clk_i(clk), .rst_ni(rst_ni), .locked_uart_i(locked_uart_i), .locked_adc_i(locked_adc_i),
        .restart_i(restart_i), .mmcm_rst_o(mmcm_rst_o), .adc_rst_no(adc_rst_no),
        .fir_rst_no(fir_rst_no), .ctrl_rst_no(ctrl_rst_no), .ready_o(ready_o),
        .uart_tick_o(uart_tick_o), .retry_cnt_o(retry_cnt_o), .lock_loss_o(lock_loss_o)
    );

    // Short-period instance that never sees lock, used to reach retry saturation quickly
    clk_rst_sequencer #(.MMCM_RST_CYCLES(2), .LOCK_TIMEOUT(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_ni), .locked_uart_i(1'b0), .locked_adc_i(1'b0),
        .restart_i(1'b0), .mmcm_rst_o(s_mmcm), .adc_rst_no(s_adc),
        .fir_rst_no(s_fir), .ctrl_rst_no(s_ctrl), .ready_o(s_rdy),
        .uart_tick_o(s_tick), .retry_cnt_o(s_retry), .lock_loss_o(s_ll)
    );

    wire [14:0] obs     = {mmcm_rst_o, adc_rst_no, fir_rst_no, ctrl_rst_no, ready_o, uart_tick_o,
                           lock_loss_o, retry_cnt_o};
    wire [14:0] sat_obs = {s_mmcm, s_adc, s_fir, s_ctrl, s_rdy, s_tick, s_ll, s_retry};

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    function automatic logic [14:0] mk(input logic m, input logic a, input logic f, input logic c,
                                       input logic r, input logic t, input logic l,
                                       input logic [7:0] rc);
        return {m, a, f, c, r, t, l, rc};
    endfunction

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_at(input string tag, input int e, input logic [14:0] v);
        sb.push_back('{tag, e, v});
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].edge_at <= edge_n) begin
            e = sb.pop_front();
            checks++;
            assert (e.edge_at == edge_n && obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h at edge %0d, expected %h at edge %0d",
                       e.tag, obs, edge_n, e.val, e.edge_at);
            end
        end
    endtask

    task automatic run_until_empty(input int budget);
        for (int i = 0; i < budget && sb.size() > 0; i++) step();
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int n);
        while (edge_n < n) step();
    endtask

    initial begin
        rst_ni        = 1'b0;
        locked_uart_i = 1'b1;
        locked_adc_i  = 1'b1;
        restart_i     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_main", obs, mk(1, 0, 0, 0, 0, 0, 0, 8'd0));
        chk("reset_sat", sat_obs, mk(1, 0, 0, 0, 0, 0, 0, 8'd0));
        rst_ni = 1'b1;

        // Clean bring-up
        expect_at("mrst_hold7",  7,   mk(1, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("mrst_fall8",  8,   mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("pre_adc72",   72,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("adc_rise73",  73,  mk(0, 1, 0, 0, 0, 0, 0, 8'd0));
        expect_at("pre_fir88",   88,  mk(0, 1, 0, 0, 0, 0, 0, 8'd0));
        expect_at("fir_rise89",  89,  mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        expect_at("pre_run104",  104, mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        expect_at("run_rise105", 105, mk(0, 1, 1, 1, 1, 0, 0, 8'd0));
        expect_at("no_tick113",  113, mk(0, 1, 1, 1, 1, 0, 0, 8'd0));
        expect_at("tick114",     114, mk(0, 1, 1, 1, 1, 1, 0, 8'd0));
        expect_at("no_tick115",  115, mk(0, 1, 1, 1, 1, 0, 0, 8'd0));
        expect_at("tick123",     123, mk(0, 1, 1, 1, 1, 1, 0, 8'd0));
        expect_at("tick132",     132, mk(0, 1, 1, 1, 1, 1, 0, 8'd0));
        run_until_empty(200);

        // Lock loss in RUN, then full re-sequence
        wait_edge(140);
        locked_uart_i = 1'b0;
        expect_at("loss_tick141", 141, mk(0, 1, 1, 1, 1, 1, 0, 8'd0));
        expect_at("loss_run142",  142, mk(0, 1, 1, 1, 1, 0, 0, 8'd0));
        expect_at("loss_fault",   143, mk(0, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("loss_mrst",    144, mk(1, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("loss_mrst_e",  151, mk(1, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("loss_wait",    152, mk(0, 0, 0, 0, 0, 0, 1, 8'd0));
        run_until_empty(40);
        wait_edge(160);
        locked_uart_i = 1'b1;
        expect_at("reseq_pre_adc", 226, mk(0, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("reseq_adc",     227, mk(0, 1, 0, 0, 0, 0, 1, 8'd0));
        expect_at("reseq_fir",     243, mk(0, 1, 1, 0, 0, 0, 1, 8'd0));
        expect_at("reseq_pre_run", 258, mk(0, 1, 1, 0, 0, 0, 1, 8'd0));
        expect_at("reseq_run",     259, mk(0, 1, 1, 1, 1, 0, 1, 8'd0));
        run_until_empty(200);

        // Asynchronous reset mid-RUN
        wait_edge(265);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1 chk("async_reset", obs, mk(1, 0, 0, 0, 0, 0, 0, 8'd0));
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;

        // One-cycle lock glitch during STABLE
        expect_at("glitch_wait_entry", 8, mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        wait_edge(36);
        locked_adc_i = 1'b0;
        step();
        locked_adc_i = 1'b1;
        expect_at("glitch_to_wait",  39,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("glitch_no_adc73", 73,  mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("glitch_pre_adc",  103, mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("glitch_adc",      104, mk(0, 1, 0, 0, 0, 0, 0, 8'd0));
        expect_at("glitch_fir",      120, mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        run_until_empty(200);

        // Restart racing a synchronised lock drop in FIR
        wait_edge(123);
        locked_adc_i = 1'b0;
        expect_at("race_fir",       125, mk(0, 1, 1, 0, 0, 0, 0, 8'd0));
        expect_at("race_mrst",      126, mk(1, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("race_mrst2",     127, mk(1, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("race_mrst_last", 133, mk(1, 0, 0, 0, 0, 0, 1, 8'd0));
        expect_at("race_mrst_fall", 134, mk(0, 0, 0, 0, 0, 0, 1, 8'd0));
        wait_edge(125);
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        step();
        locked_adc_i = 1'b1;
        wait_edge(129);
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        run_until_empty(40);

        // No lock for 3000 cycles
        rst_ni        = 1'b0;
        locked_uart_i = 1'b0;
        locked_adc_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        expect_at("nolock_mrst7",  7,    mk(1, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("nolock_wait8",  8,    mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("nolock_1031",   1031, mk(0, 0, 0, 0, 0, 0, 0, 8'd0));
        expect_at("nolock_1032",   1032, mk(1, 0, 0, 0, 0, 0, 0, 8'd1));
        expect_at("nolock_1039",   1039, mk(1, 0, 0, 0, 0, 0, 0, 8'd1));
        expect_at("nolock_1040",   1040, mk(0, 0, 0, 0, 0, 0, 0, 8'd1));
        expect_at("nolock_2063",   2063, mk(0, 0, 0, 0, 0, 0, 0, 8'd1));
        expect_at("nolock_2064",   2064, mk(1, 0, 0, 0, 0, 0, 0, 8'd2));
        expect_at("nolock_2072",   2072, mk(0, 0, 0, 0, 0, 0, 0, 8'd2));
        expect_at("nolock_3000",   3000, mk(0, 0, 0, 0, 0, 0, 0, 8'd2));
        run_until_empty(3100);
        chk("retry_saturate", {7'd0, s_retry}, {7'd0, 8'd255});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
